// File: rtl/branch_pred_ctrl.sv
// Fetch-stage next-PC controller: owns the PC, predicts beq/bne with a table of
// 2-bit saturating counters, redirects on jal and recovers on EX mispredicts.
module branch_pred_ctrl #(
   parameter int          IDX_W    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_stall,
   input  logic             i_if_br,
   input  logic             i_if_jal,
   input  logic [31:0]      i_if_imm,
   input  logic             i_ex_valid,
   input  logic             i_ex_br,
   input  logic             i_ex_taken,
   input  logic             i_ex_pred,
   input  logic [31:0]      i_ex_pc,
   input  logic [31:0]      i_ex_target,
   output logic [31:0]      o_pc,
   output logic             o_pred_taken,
   output logic             o_flush,
   output logic [CNT_W-1:0] o_br_cnt,
   output logic [CNT_W-1:0] o_miss_cnt
);
   localparam int PHT_N = 1 << IDX_W;

   logic [31:0]      pc_q, pc_d, rec_pc;
   logic             flush_q;
   logic [CNT_W-1:0] br_cnt_q, br_cnt_d, miss_cnt_q, miss_cnt_d;
   logic [1:0]       pht_q [PHT_N];
   logic [IDX_W-1:0] idx_if, idx_ex;
   logic             res, miss, pred;

   assign idx_if = pc_q[IDX_W+1:2];
   assign idx_ex = i_ex_pc[IDX_W+1:2];
   assign res    = i_ex_valid & i_ex_br;
   assign miss   = res & (i_ex_taken ^ i_ex_pred);
   assign rec_pc = i_ex_taken ? i_ex_target : i_ex_pc + 32'd4;
   assign pred   = i_if_jal | (i_if_br & pht_q[idx_if][1]);

   always_comb begin
      pc_d       = pc_q + 32'd4;
      br_cnt_d   = br_cnt_q;
      miss_cnt_d = miss_cnt_q;
      // A resolved mispredict outranks whatever the fetch stage predicted.
      if (miss)      pc_d = rec_pc;
      else if (pred) pc_d = pc_q + i_if_imm;
      if (res && (br_cnt_q != '1))    br_cnt_d   = br_cnt_q + 1'b1;
      if (miss && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pc_q       <= RESET_PC;
         flush_q    <= 1'b0;
         br_cnt_q   <= '0;
         miss_cnt_q <= '0;
      end else if (!i_stall) begin
         pc_q       <= pc_d;
         flush_q    <= miss;
         br_cnt_q   <= br_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   for (genvar k = 0; k < PHT_N; k++) begin : g_pht
      logic [1:0] cnt_d;
      always_comb begin
         cnt_d = pht_q[k];
         if (i_ex_taken && (pht_q[k] != 2'b11))       cnt_d = pht_q[k] + 2'b01;
         else if (!i_ex_taken && (pht_q[k] != 2'b00)) cnt_d = pht_q[k] - 2'b01;
      end
      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst)                                          pht_q[k] <= 2'b01;
         else if (!i_stall && res && (idx_ex == IDX_W'(k)))  pht_q[k] <= cnt_d;
      end
   end

   assign o_pc         = pc_q;
   assign o_pred_taken = pred;
   assign o_flush      = flush_q;
   assign o_br_cnt     = br_cnt_q;
   assign o_miss_cnt   = miss_cnt_q;
endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Directed bench for branch_pred_ctrl (CNT_W=4 build so counter saturation is reachable).
module tb_branch_pred_ctrl;
   logic        clk = 1'b0, rst = 1'b0, stall = 1'b0;
   logic        if_br = 1'b0, if_jal = 1'b0;
   logic [31:0] if_imm = '0;
   logic        ex_valid = 1'b0, ex_br = 1'b0, ex_taken = 1'b0, ex_pred = 1'b0;
   logic [31:0] ex_pc = '0, ex_target = '0;
   logic [31:0] pc;
   logic        pred_taken, flush;
   logic [3:0]  br_cnt, miss_cnt;
   int          tests = 0, fails = 0;

   branch_pred_ctrl #(.IDX_W(2), .RESET_PC(32'h0), .CNT_W(4)) dut (
      .i_clk(clk), .i_rst(rst), .i_stall(stall),
      .i_if_br(if_br), .i_if_jal(if_jal), .i_if_imm(if_imm),
      .i_ex_valid(ex_valid), .i_ex_br(ex_br), .i_ex_taken(ex_taken), .i_ex_pred(ex_pred),
      .i_ex_pc(ex_pc), .i_ex_target(ex_target),
      .o_pc(pc), .o_pred_taken(pred_taken), .o_flush(flush),
      .o_br_cnt(br_cnt), .o_miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic clr();
      if_br = 0; if_jal = 0; if_imm = '0;
      ex_valid = 0; ex_br = 0; ex_taken = 0; ex_pred = 0; ex_pc = '0; ex_target = '0;
   endtask

   task automatic resolve(input logic tk, input logic pr, input logic [31:0] bpc, input logic [31:0] tgt);
      ex_valid = 1; ex_br = 1; ex_taken = tk; ex_pred = pr; ex_pc = bpc; ex_target = tgt;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      clr(); stall = 0; rst = 1;
      #2 rst = 0;
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      clr(); rst = 1; #1;
      tests++; if (pc !== 32'h0 || flush !== 1'b0) begin fails++; $display("FAIL reset_state pc=%h flush=%b want 0/0", pc, flush); end
      tests++; if (br_cnt !== 4'h0 || miss_cnt !== 4'h0) begin fails++; $display("FAIL reset_cnt br=%h miss=%h want 0/0", br_cnt, miss_cnt); end
      #1 rst = 0;
      for (int i = 1; i <= 3; i++) begin
         step();
         tests++; if (pc !== 32'(4*i) || flush !== 1'b0) begin fails++; $display("FAIL seq_pc pc=%h flush=%b want %h/0", pc, flush, 32'(4*i)); end
      end
      step();
   endtask

   task automatic test_jal();
      // pc is 0x10 here
      if_jal = 1; if_imm = 32'h20; #1;
      tests++; if (pred_taken !== 1'b1) begin fails++; $display("FAIL jal_pred got %b want 1", pred_taken); end
      step(); clr();
      tests++; if (pc !== 32'h30 || br_cnt !== 4'h0 || flush !== 1'b0) begin fails++; $display("FAIL jal_redirect pc=%h br=%h flush=%b want 30/0/0", pc, br_cnt, flush); end
   endtask

   task automatic test_pht_train();
      do_reset(); step(); step();
      // pc=8, PHT[2]=01: lookup sees old value even while the same index updates
      if_br = 1; if_imm = 32'h40; resolve(1, 0, 32'h8, 32'h100); #1;
      tests++; if (pred_taken !== 1'b0) begin fails++; $display("FAIL pht_init_pred got %b want 0", pred_taken); end
      for (int i = 1; i <= 3; i++) begin
         if (i > 1) resolve(1, 0, 32'h8, 32'h100);
         step(); clr();
         tests++; if (pc !== 32'h100 || flush !== 1'b1 || miss_cnt !== 4'(i)) begin fails++; $display("FAIL train_miss%0d pc=%h flush=%b miss=%h want 100/1/%0d", i, pc, flush, miss_cnt, i); end
         step();
         tests++; if (flush !== 1'b0 || pc !== 32'h104) begin fails++; $display("FAIL train_flush_clr%0d flush=%b pc=%h want 0/104", i, flush, pc); end
      end
      // correct prediction: no flush, sequential PC; counter must saturate at 11
      resolve(1, 1, 32'h8, 32'h100); step(); clr();
      tests++; if (pc !== 32'h108 || flush !== 1'b0 || miss_cnt !== 4'd3 || br_cnt !== 4'd4) begin fails++; $display("FAIL correct_pred pc=%h flush=%b miss=%h br=%h want 108/0/3/4", pc, flush, miss_cnt, br_cnt); end
      resolve(0, 1, 32'h8, 32'h100); step();
      tests++; if (pc !== 32'h0C || flush !== 1'b1) begin fails++; $display("FAIL nt_recover pc=%h flush=%b want c/1", pc, flush); end
      resolve(0, 1, 32'h4, 32'h100); step(); clr();
      tests++; if (pc !== 32'h8 || flush !== 1'b1 || br_cnt !== 4'd6 || miss_cnt !== 4'd5) begin fails++; $display("FAIL back_to_back_miss pc=%h flush=%b br=%h miss=%h want 8/1/6/5", pc, flush, br_cnt, miss_cnt); end
      #1;
      tests++; if (pred_taken !== 1'b0) begin fails++; $display("FAIL no_br_pred got %b want 0", pred_taken); end
      if_br = 1; if_imm = 32'h40; #1;
      tests++; if (pred_taken !== 1'b1) begin fails++; $display("FAIL trained_pred got %b want 1 (PHT[2]=10)", pred_taken); end
      step(); clr();
      tests++; if (pc !== 32'h48 || flush !== 1'b0) begin fails++; $display("FAIL br_redirect pc=%h flush=%b want 48/0", pc, flush); end
   endtask

   task automatic test_miss_vs_jal();
      resolve(0, 1, 32'h40, 32'h999); if_jal = 1; if_imm = 32'h100; #1;
      tests++; if (pred_taken !== 1'b1) begin fails++; $display("FAIL missjal_pred got %b want 1", pred_taken); end
      step(); clr();
      tests++; if (pc !== 32'h44 || flush !== 1'b1) begin fails++; $display("FAIL missjal_pc pc=%h flush=%b want 44/1", pc, flush); end
      step();
      tests++; if (pc !== 32'h48 || flush !== 1'b0) begin fails++; $display("FAIL missjal_clr pc=%h flush=%b want 48/0", pc, flush); end
   endtask

   task automatic test_stall();
      logic [31:0] pc0;
      logic [3:0]  br0, miss0;
      do_reset(); step(); step();
      pc0 = pc; br0 = br_cnt; miss0 = miss_cnt;
      stall = 1; resolve(1, 0, 32'h50, 32'h200);
      for (int i = 0; i < 3; i++) begin
         step();
         tests++; if (pc !== pc0 || flush !== 1'b0 || br_cnt !== br0 || miss_cnt !== miss0) begin fails++; $display("FAIL stall_hold%0d pc=%h flush=%b br=%h miss=%h want %h/0/%h/%h", i, pc, flush, br_cnt, miss_cnt, pc0, br0, miss0); end
      end
      stall = 0; step(); clr();
      tests++; if (pc !== 32'h200 || flush !== 1'b1 || miss_cnt !== 4'd1 || br_cnt !== 4'd1) begin fails++; $display("FAIL stall_release pc=%h flush=%b miss=%h br=%h want 200/1/1/1", pc, flush, miss_cnt, br_cnt); end
      stall = 1;
      for (int i = 0; i < 2; i++) begin
         step();
         tests++; if (pc !== 32'h200 || flush !== 1'b1) begin fails++; $display("FAIL flush_held%0d pc=%h flush=%b want 200/1", i, pc, flush); end
      end
      stall = 0; step();
      tests++; if (pc !== 32'h204 || flush !== 1'b0) begin fails++; $display("FAIL flush_drop pc=%h flush=%b want 204/0", pc, flush); end
      // PHT[0] must be 10 (one update, not four): one not-taken brings it to 01
      resolve(0, 0, 32'h50, 32'h200); step(); clr();
      tests++; if (pc !== 32'h208 || flush !== 1'b0 || br_cnt !== 4'd2) begin fails++; $display("FAIL stall_nt pc=%h flush=%b br=%h want 208/0/2", pc, flush, br_cnt); end
      step(); step(); if_br = 1; if_imm = 32'h10; #1;
      tests++; if (pc !== 32'h210 || pred_taken !== 1'b0) begin fails++; $display("FAIL stall_pht pc=%h pred=%b want 210/0", pc, pred_taken); end
      clr();
   endtask

   task automatic test_wrap_sat_async();
      resolve(1, 0, 32'h60, 32'hFFFF_FFFC); step(); clr();
      tests++; if (pc !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_setup pc=%h want fffffffc", pc); end
      step();
      tests++; if (pc !== 32'h0) begin fails++; $display("FAIL pc_wrap pc=%h want 0", pc); end
      do_reset();
      for (int i = 1; i <= 20; i++) begin
         resolve(1, 0, 32'h0, 32'h300); step();
         if (i == 15 || i == 20) begin
            tests++; if (miss_cnt !== 4'hF || br_cnt !== 4'hF) begin fails++; $display("FAIL cnt_sat%0d miss=%h br=%h want f/f", i, miss_cnt, br_cnt); end
         end
      end
      tests++; if (flush !== 1'b1 || pc !== 32'h300) begin fails++; $display("FAIL pre_async flush=%b pc=%h want 1/300", flush, pc); end
      clr(); #2 rst = 1; #1;
      tests++; if (pc !== 32'h0 || flush !== 1'b0 || miss_cnt !== 4'h0 || br_cnt !== 4'h0) begin fails++; $display("FAIL async_rst pc=%h flush=%b miss=%h br=%h want 0/0/0/0", pc, flush, miss_cnt, br_cnt); end
      #1 rst = 0;
      step();
      tests++; if (pc !== 32'h4) begin fails++; $display("FAIL post_rst pc=%h want 4", pc); end
   endtask

   initial begin
      test_reset();
      test_jal();
      test_pht_train();
      test_miss_vs_jal();
      test_stall();
      test_wrap_sat_async();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout tests=%0d want completion", tests);
      $fatal(1, "timeout");
   end
endmodule
